// File: rtl/sum_cond_subtractor.sv
// Final conditional subtract of a limb-serial modular adder: R = S - N if S >= N, else S.
// Optional result counter (sub_count_out) enabled by defining SUM_COND_SUBTRACTOR_COUNT_EN.
module sum_cond_subtractor #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] sum_in,
  input  logic                     carry_in,
  input  logic [REGISTER_SIZE-1:0] modulus_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  output logic                     final_out,
`ifdef SUM_COND_SUBTRACTOR_COUNT_EN
  output logic [15:0]              sub_count_out,
`endif
  input  logic                     ready_in
);
  localparam int NUM_LIMBS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int CW        = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_LIMBS - 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t                                    state_q, state_d;
  logic [CW-1:0]                             cnt_q, idx_q;
  logic                                      borrow_q, sel_q, sel_d;
  logic [NUM_LIMBS-1:0][REGISTER_SIZE-1:0]   sum_buf_q, diff_buf_q;
  logic [REGISTER_SIZE:0]                    diff_w;
  logic                                      accept, last_in, xfer, last_out;

  // Top bit of the widened difference is the borrow out of this limb.
  assign diff_w   = {1'b0, sum_in} - {1'b0, modulus_in} - {{REGISTER_SIZE{1'b0}}, borrow_q};
  assign accept   = valid_in && (state_q == COLLECT);
  assign last_in  = accept && (cnt_q == LAST);
  assign xfer     = (state_q == DRAIN) && ready_in;
  assign last_out = xfer && (idx_q == LAST);
  assign sel_d    = carry_in | ~diff_w[REGISTER_SIZE];

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (last_in)  state_d = DRAIN;
      DRAIN:   if (last_out) state_d = COLLECT;
      default:               state_d = COLLECT;
    endcase
  end

  always_comb begin
    ready_out = (state_q == COLLECT);
    valid_out = (state_q == DRAIN);
    final_out = (state_q == DRAIN) && (idx_q == LAST);
    data_out  = sel_q ? diff_buf_q[idx_q] : sum_buf_q[idx_q];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      if (accept) begin
        if (last_in) begin
          cnt_q    <= '0;
          borrow_q <= 1'b0;
          sel_q    <= sel_d;
        end else begin
          cnt_q    <= cnt_q + 1'b1;
          borrow_q <= diff_w[REGISTER_SIZE];
        end
      end
      if (xfer) idx_q <= last_out ? '0 : idx_q + 1'b1;
    end
  end

  // Buffers are never cleared; reset only discards the bookkeeping around them.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      sum_buf_q[cnt_q]  <= sum_in;
      diff_buf_q[cnt_q] <= diff_w[REGISTER_SIZE-1:0];
    end
  end

`ifdef SUM_COND_SUBTRACTOR_COUNT_EN
  logic [15:0] sub_cnt_q;
  always_ff @(posedge clk_in) begin
    if (rst_in)                                          sub_cnt_q <= '0;
    else if (last_in && sel_d && (sub_cnt_q != 16'hFFFF)) sub_cnt_q <= sub_cnt_q + 16'd1;
  end
  assign sub_count_out = sub_cnt_q;
`endif
endmodule

// File: tb/tb_sum_cond_subtractor.sv
// Bench for sum_cond_subtractor with two 32-bit limbs; reference is plain 65-bit arithmetic.
module tb_sum_cond_subtractor;
  localparam int RS = 32;

  logic          clk = 0;
  logic          rst, carry_in, valid_in, ready_in;
  logic [RS-1:0] sum_in, modulus_in;
  logic          ready_out, valid_out, final_out;
  logic [RS-1:0] data_out;
`ifdef SUM_COND_SUBTRACTOR_COUNT_EN
  logic [15:0]   sub_count;
`endif

  int checks = 0;
  int errors = 0;

  sum_cond_subtractor #(.REGISTER_SIZE(32), .BITS_IN_NUM(64)) dut (
    .clk_in(clk), .rst_in(rst), .sum_in(sum_in), .carry_in(carry_in),
    .modulus_in(modulus_in), .valid_in(valid_in), .ready_out(ready_out),
    .data_out(data_out), .valid_out(valid_out), .final_out(final_out),
`ifdef SUM_COND_SUBTRACTOR_COUNT_EN
    .sub_count_out(sub_count),
`endif
    .ready_in(ready_in));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mod(input logic [63:0] n, input logic [64:0] s);
    return (s >= {1'b0, n}) ? 64'(s - {1'b0, n}) : s[63:0];
  endfunction

  // Drives both limbs on falling edges; optional bubble between them.
  task automatic send(input logic [63:0] n, input logic [64:0] s, input bit bubble);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (bubble && k == 1) begin
        valid_in = 0;
        sum_in   = 32'hDEAD_BEEF;
        @(negedge clk);
      end
      chk("ready_before_limb", 64'(ready_out), 64'd1);
      valid_in   = 1;
      sum_in     = (k == 0) ? s[31:0] : s[63:32];
      modulus_in = (k == 0) ? n[31:0] : n[63:32];
      carry_in   = (k == 1) ? s[64] : 1'b0;
    end
    @(negedge clk);
    valid_in = 0;
    carry_in = 0;
    chk("latency_valid", 64'(valid_out), 64'd1);
  endtask

  // Called on the negedge right after send(); leaves bench on an idle negedge.
  task automatic drain(input logic [63:0] exp, input bit stall);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] e;
      e = (k == 0) ? exp[31:0] : exp[63:32];
      if (stall && k == 1) begin
        ready_in   = 0;
        valid_in   = 1;
        sum_in     = 32'h1234_5678;
        modulus_in = 32'h0BAD_F00D;
        carry_in   = 1;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("stall_data", 64'(data_out), 64'(e));
          chk("stall_final", 64'(final_out), 64'd1);
          chk("stall_valid", 64'(valid_out), 64'd1);
        end
        valid_in = 0;
        carry_in = 0;
      end
      ready_in = 1;
      chk("data", 64'(data_out), 64'(e));
      chk("final", 64'(final_out), 64'(k == 1));
      chk("valid", 64'(valid_out), 64'd1);
      @(negedge clk);
    end
    chk("idle_ready", 64'(ready_out), 64'd1);
    chk("idle_valid", 64'(valid_out), 64'd0);
  endtask

  initial begin
    logic [63:0] n;
    logic [64:0] s;
    logic [95:0] r;
    rst = 1; valid_in = 0; ready_in = 1; carry_in = 0; sum_in = '0; modulus_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_final", 64'(final_out), 64'd0);
    rst = 0;

    send(64'd5, 65'd7, 0); drain(ref_mod(64'd5, 65'd7), 0);
    chk("ref_7_5", ref_mod(64'd5, 65'd7), 64'd2);
    send(64'd5, 65'd3, 0); drain(64'd3, 0);
    send(64'd5, 65'd5, 1); drain(64'd0, 0);
    send(64'hFFFF_FFFF_FFFF_FFFF, {1'b1, 64'd3}, 0); drain(64'd4, 0);
`ifdef SUM_COND_SUBTRACTOR_COUNT_EN
    chk("sub_count", 64'(sub_count), 64'd3);
`endif

    send(64'h0000_0007_0000_0001, 65'h0000_000A_0000_0000, 0);
    drain(ref_mod(64'h0000_0007_0000_0001, 65'h0000_000A_0000_0000), 1);

    // Reset after the first output limb has been transferred.
    send(64'd5, 65'd9, 0);
    chk("pre_rst_data", 64'(data_out), 64'd4);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("post_rst_ready", 64'(ready_out), 64'd1);
    chk("post_rst_valid", 64'(valid_out), 64'd0);
    send(64'd5, 65'd9, 0); drain(64'd4, 0);

    // Reset in the middle of collecting a number.
    @(negedge clk);
    valid_in = 1; sum_in = 32'h7777_7777; modulus_in = 32'h1; carry_in = 0;
    @(negedge clk);
    valid_in = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_valid", 64'(valid_out), 64'd0);
    send(64'd5, 65'd3, 0); drain(64'd3, 0);

    for (int i = 0; i < 40; i++) begin
      n = {$urandom, $urandom};
      if (n == 0) n = 64'd1;
      r = {$urandom, $urandom, $urandom};
      s = 65'(r % {31'b0, n, 1'b0});
      send(n, s, i[0]);
      drain(ref_mod(n, s), i % 5 == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
